// File: rtl/sig_seq_pkg.sv
// sig_seq_pkg: shared state encoding, default sizes and counter-width helper for the frame sequencer
package sig_seq_pkg;
  typedef enum logic [2:0] {IDLE, INIT, FEED, DRAIN, NEXT, DONE_ST, ERR} state_t;
  localparam int DEF_FRAME_LEN = 256;
  localparam int DEF_PROFILE_LEN = 21;
  localparam int DEF_NUM_FRAMES = 32;
  localparam int DEF_INIT_CYCLES = 4;
  localparam int DEF_TIMEOUT = 65535;
  localparam int FRAME_W = 8;
  function automatic int cnt_w(input int n);
    return $clog2(n + 1);
  endfunction
  localparam int DEF_SAMP_W = cnt_w(DEF_FRAME_LEN);
  localparam int DEF_PROF_W = cnt_w(DEF_PROFILE_LEN);
endpackage

// File: rtl/sig_seq_watchdog.sv
// sig_seq_watchdog: idle-cycle counter with clear, saturating increment and terminal-count flag
module sig_seq_watchdog
  import sig_seq_pkg::*;
#(
  parameter int TIMEOUT = DEF_TIMEOUT
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic inc,
  output logic expire
);
  localparam int W = cnt_w(TIMEOUT);
  logic [W-1:0] cnt;
  always_ff @(posedge clk or posedge rst)
    if (rst) cnt <= '0;
    else if (clr) cnt <= '0;
    else if (inc && cnt != W'(TIMEOUT)) cnt <= cnt + 1'b1;
  // flags the idle cycle that brings the count to TIMEOUT
  assign expire = inc && !clr && cnt == W'(TIMEOUT - 1);
endmodule

// File: rtl/sig_frame_sequencer.sv
// sig_frame_sequencer: runs NUM_FRAMES init/feed/drain frames around the signal core with watchdog and abort
module sig_frame_sequencer
  import sig_seq_pkg::*;
#(
  parameter int FRAME_LEN   = DEF_FRAME_LEN,
  parameter int PROFILE_LEN = DEF_PROFILE_LEN,
  parameter int NUM_FRAMES  = DEF_NUM_FRAMES,
  parameter int INIT_CYCLES = DEF_INIT_CYCLES,
  parameter int TIMEOUT     = DEF_TIMEOUT
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic         abort,
  output logic         busy,
  output logic         done,
  output logic         error,
  output logic [7:0]   frame_idx,
  input  logic [15:0]  src_audio_data,
  input  logic         src_audio_valid,
  output logic         src_audio_rdy,
  output logic         core_init,
  output logic [15:0]  core_audio_data,
  output logic         core_audio_valid,
  input  logic         core_audio_rdy,
  input  logic [15:0]  core_profile_data,
  input  logic         core_profile_valid,
  output logic         core_profile_rdy,
  output logic [15:0]  out_profile_data,
  output logic         out_profile_valid,
  input  logic         out_profile_rdy,
  output logic         out_profile_last,
  output logic         out_run_last
);
  localparam int SW = cnt_w(FRAME_LEN);
  localparam int PW = cnt_w(PROFILE_LEN);
  localparam int IW = cnt_w(INIT_CYCLES);
  state_t state, state_n;
  logic [SW-1:0] samp_cnt;
  logic [PW-1:0] prof_cnt;
  logic [IW-1:0] init_cnt;
  logic feed, prof_act, a_xfer, p_xfer, prof_fin, last_frame, go, expire, wd_clr;
  assign feed = state == FEED;
  // profile path stays open across FEED and DRAIN until the frame's words are in
  assign prof_act = (feed || state == DRAIN) && prof_cnt < PW'(PROFILE_LEN);
  assign src_audio_rdy = feed & core_audio_rdy;
  assign core_audio_valid = feed & src_audio_valid;
  assign core_audio_data = feed ? src_audio_data : '0;
  assign core_profile_rdy = prof_act & out_profile_rdy;
  assign out_profile_valid = prof_act & core_profile_valid;
  assign out_profile_data = prof_act ? core_profile_data : '0;
  assign last_frame = frame_idx == FRAME_W'(NUM_FRAMES - 1);
  assign out_profile_last = out_profile_valid && prof_cnt == PW'(PROFILE_LEN - 1);
  assign out_run_last = out_profile_last && last_frame;
  assign a_xfer = src_audio_valid & src_audio_rdy;
  assign p_xfer = out_profile_valid & out_profile_rdy;
  assign prof_fin = prof_cnt == PW'(PROFILE_LEN) || (p_xfer && prof_cnt == PW'(PROFILE_LEN - 1));
  assign go = (state == IDLE || state == DONE_ST || state == ERR) && start && !abort;
  assign busy = state inside {INIT, FEED, DRAIN, NEXT};
  assign core_init = state == INIT;
  assign wd_clr = !(feed || state == DRAIN) || a_xfer || p_xfer;
  sig_seq_watchdog #(.TIMEOUT(TIMEOUT)) u_wd (
    .clk(clk),
    .rst(rst),
    .clr(wd_clr),
    .inc(!wd_clr),
    .expire(expire)
  );
  always_comb begin
    state_n = state;
    case (state)
      IDLE, DONE_ST, ERR: state_n = start ? INIT : state;
      INIT: state_n = init_cnt == IW'(INIT_CYCLES - 1) ? FEED : INIT;
      FEED: state_n = expire ? ERR : (a_xfer && samp_cnt == SW'(FRAME_LEN - 1)) ? DRAIN : FEED;
      DRAIN: state_n = prof_fin ? NEXT : expire ? ERR : DRAIN;
      NEXT: state_n = last_frame ? DONE_ST : INIT;
      default: state_n = IDLE;
    endcase
    if (abort) state_n = IDLE;
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state <= IDLE;
      samp_cnt <= '0;
      prof_cnt <= '0;
      init_cnt <= '0;
      frame_idx <= '0;
      done <= 1'b0;
      error <= 1'b0;
    end else begin
      state <= state_n;
      done <= state == NEXT && state_n == DONE_ST;
      error <= go ? 1'b0 : state_n == ERR ? 1'b1 : error;
      init_cnt <= (state == INIT && init_cnt != IW'(INIT_CYCLES)) ? init_cnt + 1'b1 : '0;
      if (go || (state == NEXT && state_n == INIT)) begin
        frame_idx <= go ? '0 : frame_idx + 1'b1;
        samp_cnt <= '0;
        prof_cnt <= '0;
      end else begin
        if (a_xfer && samp_cnt != SW'(FRAME_LEN)) samp_cnt <= samp_cnt + 1'b1;
        if (p_xfer) prof_cnt <= prof_cnt + 1'b1;
      end
    end
endmodule

// File: tb/tb_sig_frame_sequencer.sv
// tb_sig_frame_sequencer: directed scenarios against a small core model for sig_frame_sequencer
module tb_sig_frame_sequencer;
  logic clk = 0, rst = 1, start = 0, abort = 0;
  logic busy, done, error, src_audio_rdy, core_init, core_audio_valid, core_profile_rdy;
  logic out_profile_valid, out_profile_last, out_run_last, core_profile_valid;
  logic src_audio_valid = 1, core_audio_rdy = 1, out_profile_rdy = 1;
  logic [7:0] frame_idx;
  logic [15:0] src_audio_data, core_audio_data, core_profile_data, out_profile_data;
  logic [15:0] src_word = 16'h0100;
  logic [49:0] ov;
  int acc = 0, emitted = 0, wtot = 0, emit_after = 4;
  int pass = 0, total = 0;
  int n_samp = 0, n_init = 0, n_done = 0, n_stall = 0, bad_fwd = 0;
  int spf[2] = '{0, 0};
  logic [15:0] wq[$];
  bit lq[$], rq[$];
  int fq[$], sq[$];

  always #5 clk = ~clk;

  sig_frame_sequencer #(.FRAME_LEN(4), .PROFILE_LEN(2), .NUM_FRAMES(2), .INIT_CYCLES(2), .TIMEOUT(16)) dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort), .busy(busy), .done(done), .error(error),
    .frame_idx(frame_idx), .src_audio_data(src_audio_data), .src_audio_valid(src_audio_valid),
    .src_audio_rdy(src_audio_rdy), .core_init(core_init), .core_audio_data(core_audio_data),
    .core_audio_valid(core_audio_valid), .core_audio_rdy(core_audio_rdy),
    .core_profile_data(core_profile_data), .core_profile_valid(core_profile_valid),
    .core_profile_rdy(core_profile_rdy), .out_profile_data(out_profile_data),
    .out_profile_valid(out_profile_valid), .out_profile_rdy(out_profile_rdy),
    .out_profile_last(out_profile_last), .out_run_last(out_run_last)
  );

  assign ov = {busy, done, error, core_init, src_audio_rdy, core_audio_valid, core_profile_rdy,
               out_profile_valid, out_profile_last, out_run_last, frame_idx, core_audio_data, out_profile_data};
  assign src_audio_data = src_word;
  // core model: after emit_after samples of a frame it offers two profile words
  assign core_profile_valid = acc >= emit_after && emitted < 2;
  assign core_profile_data = 16'hA000 + 16'(wtot);

  always @(posedge clk or posedge rst)
    if (rst) begin
      acc <= 0;
      emitted <= 0;
    end else if (core_init) begin
      acc <= 0;
      emitted <= 0;
    end else begin
      if (core_audio_valid && core_audio_rdy) acc <= acc + 1;
      if (core_profile_valid && core_profile_rdy) emitted <= emitted + 1;
    end

  always @(posedge clk) begin
    if (src_audio_valid && src_audio_rdy) src_word <= src_word + 16'd1;
    if (core_profile_valid && core_profile_rdy) wtot <= wtot + 1;
  end

  always @(negedge clk)
    if (!rst) begin
      if (out_profile_valid && out_profile_rdy) begin
        wq.push_back(out_profile_data);
        lq.push_back(out_profile_last);
        rq.push_back(out_run_last);
        fq.push_back(int'(frame_idx));
        sq.push_back(n_samp);
        if (!core_profile_rdy) bad_fwd++;
      end
      if (out_profile_valid && !out_profile_rdy) n_stall++;
      if (src_audio_valid && src_audio_rdy) begin
        n_samp++;
        spf[frame_idx[0]]++;
        if (core_audio_data !== src_audio_data || !core_audio_valid) bad_fwd++;
      end
      if (core_init) n_init++;
      if (done) n_done++;
    end

  task automatic test_reset();
    @(negedge clk);
    total++; if (ov !== '0) $display("FAIL reset_outputs: got %h want 0", ov); else pass++;
    rst = 0;
    @(negedge clk);
    total++; if (ov !== '0) $display("FAIL idle_outputs: got %h want 0", ov); else pass++;
    total++; if (dut.state !== sig_seq_pkg::IDLE) $display("FAIL reset_state: got %0d want IDLE", dut.state); else pass++;
  endtask

  task automatic test_nominal();
    int kd = -1, bs = n_samp, bw = wq.size(), bi = n_init, bd = n_done, base = wtot, bf = bad_fwd;
    bit el[4] = '{0, 1, 0, 1};
    bit er[4] = '{0, 0, 0, 1};
    int ef[4] = '{0, 0, 1, 1};
    @(posedge clk); #1 start = 1;
    for (int k = 1; k <= 60 && kd < 0; k++) begin
      @(posedge clk); #1 start = 0;
      @(negedge clk);
      if (k == 1) begin
        total++; if (frame_idx !== 8'd0 || core_init !== 1'b1 || busy !== 1'b1)
          $display("FAIL nom_first_cycle: got idx=%0d init=%b busy=%b want 0 1 1", frame_idx, core_init, busy); else pass++;
      end
      if (done) kd = k;
    end
    repeat (3) @(negedge clk);
    total++; if (kd !== 19) $display("FAIL nom_done_cycle: got %0d want 19", kd); else pass++;
    total++; if (n_samp - bs !== 8) $display("FAIL nom_samples: got %0d want 8", n_samp - bs); else pass++;
    total++; if (n_init - bi !== 4) $display("FAIL nom_init_cycles: got %0d want 4", n_init - bi); else pass++;
    total++; if (n_done - bd !== 1) $display("FAIL nom_done_pulses: got %0d want 1", n_done - bd); else pass++;
    total++; if (wq.size() - bw !== 4) $display("FAIL nom_words: got %0d want 4", wq.size() - bw); else pass++;
    total++; if (bad_fwd !== bf) $display("FAIL nom_forwarding: got %0d errors want 0", bad_fwd - bf); else pass++;
    for (int i = 0; i < 4; i++) begin
      total++;
      if (wq[bw+i] !== 16'hA000 + 16'(base + i) || lq[bw+i] !== el[i] || rq[bw+i] !== er[i] || fq[bw+i] !== ef[i])
        $display("FAIL nom_word%0d: got d=%h last=%b rlast=%b idx=%0d want d=%h last=%b rlast=%b idx=%0d", i,
                 wq[bw+i], lq[bw+i], rq[bw+i], fq[bw+i], 16'hA000 + 16'(base + i), el[i], er[i], ef[i]);
      else pass++;
    end
    total++; if (busy !== 1'b0 || error !== 1'b0 || frame_idx !== 8'd1)
      $display("FAIL nom_end: got busy=%b err=%b idx=%0d want 0 0 1", busy, error, frame_idx); else pass++;
  endtask

  task automatic test_backpressure();
    int kd = -1, bw = wq.size(), bs0 = spf[0], bs1 = spf[1], bst = n_stall, base = wtot, bf = bad_fwd, hold = 0;
    bit used = 0;
    @(posedge clk); #1 start = 1;
    for (int k = 1; k <= 200 && kd < 0; k++) begin
      @(posedge clk); #1 start = 0;
      src_audio_valid = k[0];
      if (!used && core_profile_valid) begin
        used = 1;
        hold = 3;
      end
      out_profile_rdy = hold == 0;
      if (hold > 0) hold--;
      @(negedge clk);
      if (done) kd = k;
    end
    src_audio_valid = 1;
    out_profile_rdy = 1;
    repeat (3) @(negedge clk);
    total++; if (kd < 0) $display("FAIL bp_done: got no done want done"); else pass++;
    total++; if (spf[0] - bs0 !== 4 || spf[1] - bs1 !== 4)
      $display("FAIL bp_samples_per_frame: got %0d,%0d want 4,4", spf[0] - bs0, spf[1] - bs1); else pass++;
    total++; if (n_stall - bst !== 3) $display("FAIL bp_stall_cycles: got %0d want 3", n_stall - bst); else pass++;
    total++; if (wq.size() - bw !== 4 || bad_fwd !== bf)
      $display("FAIL bp_words: got %0d words %0d errors want 4 0", wq.size() - bw, bad_fwd - bf); else pass++;
    for (int i = 0; i < 4; i++) begin
      total++; if (wq[bw+i] !== 16'hA000 + 16'(base + i))
        $display("FAIL bp_word%0d: got %h want %h", i, wq[bw+i], 16'hA000 + 16'(base + i)); else pass++;
    end
  endtask

  task automatic test_early_profile();
    int kd = -1, bw = wq.size(), bs = n_samp;
    int es[4] = '{2, 3, 6, 7};
    emit_after = 2;
    @(posedge clk); #1 start = 1;
    for (int k = 1; k <= 60 && kd < 0; k++) begin
      @(posedge clk); #1 start = 0;
      @(negedge clk);
      if (done) kd = k;
    end
    emit_after = 4;
    repeat (2) @(negedge clk);
    total++; if (kd !== 17) $display("FAIL early_done_cycle: got %0d want 17", kd); else pass++;
    for (int i = 0; i < 4; i++) begin
      total++; if (sq[bw+i] - bs !== es[i])
        $display("FAIL early_word%0d_position: got %0d samples before want %0d", i, sq[bw+i] - bs, es[i]); else pass++;
    end
  endtask

  task automatic test_watchdog();
    int kd = -1;
    @(posedge clk); #1 start = 1;
    for (int k = 1; k <= 30; k++) begin
      @(posedge clk); #1 start = 0;
      core_audio_rdy = frame_idx == 8'd0;
      @(negedge clk);
      if (k == 27) begin
        total++; if (error !== 1'b0 || busy !== 1'b1)
          $display("FAIL wd_before: got err=%b busy=%b want 0 1", error, busy); else pass++;
      end
      if (k == 28) begin
        total++; if (error !== 1'b1 || frame_idx !== 8'd1) $display("FAIL wd_error: got err=%b idx=%0d want 1 1", error, frame_idx); else pass++;
        total++; if ({busy, src_audio_rdy, core_audio_valid, core_profile_rdy, out_profile_valid, core_init} !== 6'b0)
          $display("FAIL wd_handshakes: got %b want 000000",
                   {busy, src_audio_rdy, core_audio_valid, core_profile_rdy, out_profile_valid, core_init}); else pass++;
      end
    end
    total++; if (error !== 1'b1) $display("FAIL wd_sticky: got %b want 1", error); else pass++;
    core_audio_rdy = 1;
    @(posedge clk); #1 start = 1;
    for (int k = 1; k <= 60 && kd < 0; k++) begin
      @(posedge clk); #1 start = 0;
      @(negedge clk);
      if (k == 1) begin
        total++; if (error !== 1'b0 || frame_idx !== 8'd0 || core_init !== 1'b1)
          $display("FAIL wd_restart: got err=%b idx=%0d init=%b want 0 0 1", error, frame_idx, core_init); else pass++;
      end
      if (done) kd = k;
    end
    total++; if (kd !== 19) $display("FAIL wd_rerun_done: got %0d want 19", kd); else pass++;
  endtask

  task automatic test_abort();
    int bw, bd;
    @(posedge clk); #1 abort = 1;
    @(posedge clk); #1 abort = 0; start = 1; abort = 1;
    @(posedge clk); #1 start = 0; abort = 0;
    @(negedge clk);
    total++; if (busy !== 1'b0 || core_init !== 1'b0)
      $display("FAIL abort_start_idle: got busy=%b init=%b want 0 0", busy, core_init); else pass++;
    bw = wq.size();
    bd = n_done;
    @(posedge clk); #1 start = 1;
    for (int k = 1; k <= 30; k++) begin
      @(posedge clk); #1 start = 0;
      abort = k == 7;
      @(negedge clk);
      if (k == 7) begin
        total++; if (busy !== 1'b1 || out_profile_valid !== 1'b1)
          $display("FAIL abort_drain_pre: got busy=%b valid=%b want 1 1", busy, out_profile_valid); else pass++;
      end
      if (k == 8) begin
        total++; if ({busy, out_profile_valid, core_profile_rdy, core_init} !== 4'b0)
          $display("FAIL abort_drain_post: got %b want 0000", {busy, out_profile_valid, core_profile_rdy, core_init}); else pass++;
      end
    end
    total++; if (wq.size() - bw !== 1 || n_done !== bd || error !== 1'b0)
      $display("FAIL abort_drain_effects: got words=%0d done=%0d err=%b want 1 0 0", wq.size() - bw, n_done - bd, error); else pass++;
  endtask

  task automatic test_async_reset();
    @(posedge clk); #1 start = 1;
    for (int k = 1; k <= 4; k++) begin
      @(posedge clk); #1 start = 0;
      @(negedge clk);
    end
    total++; if (busy !== 1'b1 || src_audio_rdy !== 1'b1)
      $display("FAIL rst_pre_feed: got busy=%b rdy=%b want 1 1", busy, src_audio_rdy); else pass++;
    #2 rst = 1;
    #1;
    total++; if (ov !== '0) $display("FAIL rst_async_outputs: got %h want 0", ov); else pass++;
    total++; if (dut.state !== sig_seq_pkg::IDLE) $display("FAIL rst_async_state: got %0d want IDLE", dut.state); else pass++;
    @(negedge clk) rst = 0;
    @(negedge clk);
    total++; if (busy !== 1'b0 || core_init !== 1'b0)
      $display("FAIL rst_after_release: got busy=%b init=%b want 0 0", busy, core_init); else pass++;
  endtask

  initial begin
    test_reset();
    test_nominal();
    test_backpressure();
    test_early_profile();
    test_watchdog();
    test_abort();
    test_async_reset();
    $display("%0d/%0d checks passed", pass, total);
    $finish;
  end
endmodule
